// File: rtl/apple_sprite_loader.sv
// Write-side loader for the 16x16 apple sprite BRAM: packs a 4-bit-pixel byte stream into 32-bit
// words on port A. Optional trailer checksum check is enabled by APPLE_LOADER_CHECKSUM_EN.
module apple_sprite_loader #(
    parameter int unsigned WORDS  = 32,
    parameter int unsigned ADDR_W = 5,
    parameter int unsigned DATA_W = 32
) (
    input  logic              clk_125MHz,
    input  logic              reset,
    input  logic              start,
    input  logic [7:0]        s_data,
    input  logic              s_valid,
    output logic              s_ready,
    output logic [3:0]        wea,
    output logic [ADDR_W-1:0] addra,
    output logic [DATA_W-1:0] dina,
    output logic              ena,
    output logic              busy,
    output logic              loaded,
    output logic              err
);

    typedef enum logic [2:0] {StIdle, StLoad, StWrite, StCheck, StDone} state_e;

    localparam logic [ADDR_W-1:0] LastWord = ADDR_W'(WORDS - 1);

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   word_q, word_d;
    logic [ADDR_W-1:0]   addr_q, addr_d;
    logic [1:0]          byte_q, byte_d;
    logic [DATA_W-1:0]   data_q, data_d;
    logic                xfer;

`ifdef APPLE_LOADER_CHECKSUM_EN
    logic [7:0] sum_q, sum_d;
    logic       err_q, err_d;
`endif

    assign xfer = s_valid && s_ready;

    always_ff @(posedge clk_125MHz) begin
        if (reset) begin
            state_q <= StIdle;
            word_q  <= '0;
            addr_q  <= '0;
            byte_q  <= '0;
            data_q  <= '0;
`ifdef APPLE_LOADER_CHECKSUM_EN
            sum_q   <= '0;
            err_q   <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            word_q  <= word_d;
            addr_q  <= addr_d;
            byte_q  <= byte_d;
            data_q  <= data_d;
`ifdef APPLE_LOADER_CHECKSUM_EN
            sum_q   <= sum_d;
            err_q   <= err_d;
`endif
        end
    end

    always_comb begin
        state_d = state_q;
        word_d  = word_q;
        addr_d  = addr_q;
        byte_d  = byte_q;
        data_d  = data_q;
`ifdef APPLE_LOADER_CHECKSUM_EN
        sum_d   = sum_q;
        err_d   = err_q;
`endif
        // start restarts from any state; a WRITE in this cycle still drives the BRAM.
        if (start) begin
            state_d = StLoad;
            word_d  = '0;
            byte_d  = '0;
`ifdef APPLE_LOADER_CHECKSUM_EN
            sum_d   = '0;
            err_d   = 1'b0;
`endif
        end else begin
            case (state_q)
                StLoad: begin
                    if (xfer) begin
                        data_d[{byte_q, 3'b000} +: 8] = s_data;
                        byte_d = byte_q + 2'd1;
`ifdef APPLE_LOADER_CHECKSUM_EN
                        sum_d  = sum_q + s_data;
`endif
                        if (byte_q == 2'd3) begin
                            state_d = StWrite;
                            addr_d  = word_q;
                        end
                    end
                end
                StWrite: begin
                    if (word_q == LastWord) begin
`ifdef APPLE_LOADER_CHECKSUM_EN
                        state_d = StCheck;
`else
                        state_d = StDone;
`endif
                    end else begin
                        word_d  = word_q + 1'b1;
                        byte_d  = '0;
                        state_d = StLoad;
                    end
                end
`ifdef APPLE_LOADER_CHECKSUM_EN
                StCheck: begin
                    if (xfer) begin
                        err_d   = (sum_q + s_data) != 8'h00;
                        state_d = StDone;
                    end
                end
`endif
                default: ;
            endcase
        end
    end

    always_comb begin
        s_ready = (state_q == StLoad) || (state_q == StCheck);
        ena     = (state_q == StWrite);
        wea     = ena ? 4'hF : 4'h0;
        busy    = (state_q == StLoad) || (state_q == StWrite) || (state_q == StCheck);
        loaded  = (state_q == StDone);
        addra   = addr_q;
        dina    = data_q;
`ifdef APPLE_LOADER_CHECKSUM_EN
        err     = err_q;
`else
        err     = 1'b0;
`endif
    end

endmodule

// File: tb/tb_apple_sprite_loader.sv
// Directed bench for apple_sprite_loader: cycle vector table plus multi-cycle load sequences.
module tb_apple_sprite_loader;

    logic        clk_125MHz = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [7:0]  s_data = 8'h00;
    logic        s_valid = 1'b0;
    logic        s_ready;
    logic [3:0]  wea;
    logic [4:0]  addra;
    logic [31:0] dina;
    logic        ena;
    logic        busy;
    logic        loaded;
    logic        err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [4:0]  wr_addr [512];
    logic [31:0] wr_data [512];
    logic [3:0]  wr_wea  [512];
    int          wr_n = 0;

    apple_sprite_loader #(.WORDS(32), .ADDR_W(5), .DATA_W(32)) dut (
        .clk_125MHz(clk_125MHz),
        .reset     (reset),
        .start     (start),
        .s_data    (s_data),
        .s_valid   (s_valid),
        .s_ready   (s_ready),
        .wea       (wea),
        .addra     (addra),
        .dina      (dina),
        .ena       (ena),
        .busy      (busy),
        .loaded    (loaded),
        .err       (err)
    );

    always #4 clk_125MHz = ~clk_125MHz;

    always @(negedge clk_125MHz) begin
        if (ena && wr_n < 512) begin
            wr_addr[wr_n] = addra;
            wr_data[wr_n] = dina;
            wr_wea[wr_n]  = wea;
            wr_n++;
        end
    end

    typedef struct {
        logic        st;
        logic        vld;
        logic [7:0]  dat;
        logic        rdy;
        logic        en;
        logic [4:0]  adr;
        logic [31:0] din;
        logic        chk_din;
        logic        bsy;
    } vec_t;

    vec_t vecs [22];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk_125MHz);
        #1;
    endtask

    task automatic do_reset();
        reset = 1'b1; start = 1'b0; s_valid = 1'b0; s_data = 8'h00;
        step();
        step();
        reset = 1'b0;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        step();
        start = 1'b0;
    endtask

    function automatic logic [31:0] word_exp(input logic [7:0] base, input int w);
        logic [7:0] b;
        b = base + 8'(4 * w);
        return {b + 8'd3, b + 8'd2, b + 8'd1, b};
    endfunction

    // Offers bytes base+i until n are accepted; optionally checks the s_ready bubble.
    task automatic stream(input int n, input logic [7:0] base, input bit toggle, input bit chk_rdy);
        int  i = 0;
        int  cyc = 0;
        bit  acc;
        bit  after4 = 1'b0;
        while (i < n && cyc < 2000) begin
            s_valid = toggle ? (cyc % 2 == 0) : 1'b1;
            s_data  = base + 8'(i);
            #2;
            if (chk_rdy)
                chk($sformatf("s_ready_cyc%0d", cyc), 32'(s_ready), after4 ? 32'd0 : 32'd1);
            acc = s_valid && s_ready;
            step();
            after4 = 1'b0;
            if (acc) begin
                i++;
                if (i % 4 == 0) after4 = 1'b1;
            end
            cyc++;
        end
        s_valid = 1'b0;
        if (i < n) chk("stream_timeout", 32'(i), 32'(n));
    endtask

    task automatic check_image(input string tag, input int base, input logic [7:0] first);
        chk({tag, "_write_count"}, 32'(wr_n - base), 32'd32);
        for (int w = 0; w < 32; w++) begin
            chk($sformatf("%s_addr%0d", tag, w), 32'(wr_addr[base + w]), 32'(w));
            chk($sformatf("%s_data%0d", tag, w), wr_data[base + w], word_exp(first, w));
            chk($sformatf("%s_wea%0d", tag, w), 32'(wr_wea[base + w]), 32'hF);
        end
    endtask

    initial begin
        int base;
        int base2;

        vecs[0]  = '{1'b0, 1'b1, 8'hAA, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
        vecs[1]  = '{1'b1, 1'b1, 8'hAB, 1'b0, 1'b0, 5'd0, 32'h0, 1'b1, 1'b0};
        vecs[2]  = '{1'b0, 1'b1, 8'h11, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[3]  = '{1'b0, 1'b0, 8'hFF, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[4]  = '{1'b0, 1'b1, 8'h22, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[5]  = '{1'b0, 1'b1, 8'h33, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[6]  = '{1'b0, 1'b1, 8'h44, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[7]  = '{1'b0, 1'b1, 8'h55, 1'b0, 1'b1, 5'd0, 32'h44332211, 1'b1, 1'b1};
        vecs[8]  = '{1'b0, 1'b1, 8'h55, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[9]  = '{1'b0, 1'b1, 8'h66, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[10] = '{1'b0, 1'b1, 8'h77, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[11] = '{1'b0, 1'b1, 8'h88, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};
        vecs[12] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd1, 32'h88776655, 1'b1, 1'b1};
        vecs[13] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[14] = '{1'b0, 1'b1, 8'h99, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[15] = '{1'b1, 1'b0, 8'h00, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[16] = '{1'b0, 1'b1, 8'hA1, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[17] = '{1'b0, 1'b1, 8'hA2, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[18] = '{1'b0, 1'b1, 8'hA3, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[19] = '{1'b0, 1'b1, 8'hA4, 1'b1, 1'b0, 5'd1, 32'h0, 1'b0, 1'b1};
        vecs[20] = '{1'b0, 1'b0, 8'h00, 1'b0, 1'b1, 5'd0, 32'hA4A3A2A1, 1'b1, 1'b1};
        vecs[21] = '{1'b0, 1'b0, 8'h00, 1'b1, 1'b0, 5'd0, 32'h0, 1'b0, 1'b1};

        do_reset();
        chk("reset_err", 32'(err), 32'd0);
        for (int v = 0; v < 22; v++) begin
            start   = vecs[v].st;
            s_valid = vecs[v].vld;
            s_data  = vecs[v].dat;
            #2;
            chk($sformatf("v%0d_s_ready", v), 32'(s_ready), 32'(vecs[v].rdy));
            chk($sformatf("v%0d_ena", v), 32'(ena), 32'(vecs[v].en));
            chk($sformatf("v%0d_wea", v), 32'(wea), vecs[v].en ? 32'hF : 32'h0);
            chk($sformatf("v%0d_addra", v), 32'(addra), 32'(vecs[v].adr));
            chk($sformatf("v%0d_busy", v), 32'(busy), 32'(vecs[v].bsy));
            chk($sformatf("v%0d_loaded", v), 32'(loaded), 32'd0);
            if (vecs[v].chk_din)
                chk($sformatf("v%0d_dina", v), dina, vecs[v].din);
            step();
        end
        start = 1'b0; s_valid = 1'b0;

        // Full image, continuous valid
        do_reset();
        base = wr_n;
        pulse_start();
        stream(128, 8'h10, 1'b0, 1'b0);
        repeat (3) step();
        check_image("full", base, 8'h10);
        chk("full_word0", wr_data[base], 32'h13121110);
        chk("full_loaded", 32'(loaded), 32'd1);
        chk("full_busy", 32'(busy), 32'd0);
        chk("full_s_ready", 32'(s_ready), 32'd0);
        chk("full_err", 32'(err), 32'd0);
        base2 = wr_n;
        s_valid = 1'b1; s_data = 8'h5A;
        repeat (4) step();
        s_valid = 1'b0;
        chk("done_no_writes", 32'(wr_n), 32'(base2));
        chk("done_loaded_held", 32'(loaded), 32'd1);

        // Restart from DONE, valid toggling every other cycle
        base = wr_n;
        pulse_start();
        chk("restart_loaded_clr", 32'(loaded), 32'd0);
        chk("restart_busy", 32'(busy), 32'd1);
        stream(128, 8'h10, 1'b1, 1'b1);
        repeat (3) step();
        check_image("toggle", base, 8'h10);
        chk("toggle_loaded", 32'(loaded), 32'd1);

        // Restart after 10 bytes
        base = wr_n;
        pulse_start();
        stream(10, 8'h20, 1'b0, 1'b0);
        repeat (2) step();
        chk("mid_writes_before", 32'(wr_n - base), 32'd2);
        pulse_start();
        base2 = wr_n;
        stream(4, 8'hC0, 1'b0, 1'b0);
        repeat (2) step();
        chk("mid_restart_count", 32'(wr_n - base2), 32'd1);
        chk("mid_restart_addr", 32'(wr_addr[base2]), 32'd0);
        chk("mid_restart_data", wr_data[base2], 32'hC3C2C1C0);

        // Reset during word 5
        pulse_start();
        stream(22, 8'h30, 1'b0, 1'b0);
        reset = 1'b1; s_valid = 1'b1; s_data = 8'h77;
        step();
        chk("rst_s_ready", 32'(s_ready), 32'd0);
        chk("rst_wea", 32'(wea), 32'd0);
        chk("rst_ena", 32'(ena), 32'd0);
        chk("rst_addra", 32'(addra), 32'd0);
        chk("rst_dina", dina, 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_loaded", 32'(loaded), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        reset = 1'b0;
        base2 = wr_n;
        s_data = 8'hEE;
        repeat (20) step();
        chk("rst_no_writes", 32'(wr_n), 32'(base2));
        chk("rst_loaded_after", 32'(loaded), 32'd0);
        chk("rst_idle_ready", 32'(s_ready), 32'd0);

        // Bytes offered in IDLE must not be captured
        s_valid = 1'b0;
        base = wr_n;
        pulse_start();
        stream(128, 8'h10, 1'b0, 1'b0);
        repeat (3) step();
        check_image("idle_pre", base, 8'h10);
        chk("idle_pre_loaded", 32'(loaded), 32'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
